// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath types for the fetch stage
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } lc3b_if_state;

  localparam lc3b_word PC_RESET = 16'h0000;
  localparam lc3b_word PC_STEP  = 16'h0002;

  // Sequential fetch address; wraps modulo 2^16 by construction.
  function automatic lc3b_word pc_inc(input lc3b_word pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// rtl/if_skid_buffer.sv - one-entry holding slot for a fetched word the decode stage cannot take yet
import lc3b_types::*;

module if_skid_buffer (
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     clear,
  input  lc3b_word data_in,
  input  lc3b_word pc_in,
  output logic     full,
  output lc3b_word data_out,
  output lc3b_word pc_out
);

  logic     full_q, full_d;
  lc3b_word data_q, data_d;
  lc3b_word pc_q, pc_d;

  // Clear wins over load so a redirect always empties the slot.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = data_in;
      pc_d   = pc_in;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= 16'h0000;
      pc_q   <= 16'h0000;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  assign full     = full_q;
  assign data_out = data_q;
  assign pc_out   = pc_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - LC-3b instruction fetch stage with IF/ID register, skid slot and redirect flush
import lc3b_types::*;

module if_stage (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_id_valid,
  output logic [15:0] if_id_ir,
  output logic [15:0] if_id_pc
);

  lc3b_if_state state_q, state_d;
  lc3b_word     pc_q, pc_d;
  lc3b_word     pending_pc_q, pending_pc_d;
  logic         if_id_valid_q, if_id_valid_d;
  lc3b_word     if_id_ir_q, if_id_ir_d;
  lc3b_word     if_id_pc_q, if_id_pc_d;

  logic         skid_load, skid_clear, skid_full;
  lc3b_word     skid_data, skid_pc;
  lc3b_word     pc_plus2;

  assign pc_plus2 = pc_inc(pc_q);

  if_skid_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_load),
    .clear    (skid_clear),
    .data_in  (imem_rdata),
    .pc_in    (pc_plus2),
    .full     (skid_full),
    .data_out (skid_data),
    .pc_out   (skid_pc)
  );

  // Next-state, PC and IF/ID update; redirect is checked first in every state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_pc_d  = pending_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_ir_d    = if_id_ir_q;
    if_id_pc_d    = if_id_pc_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;

    if (redirect) begin
      if_id_valid_d = 1'b0;
      skid_clear    = 1'b1;
    end

    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (imem_resp) begin
            pc_d = redirect_pc;
          end else begin
            pending_pc_d = redirect_pc;
            state_d      = FLUSH;
          end
        end else if (imem_resp) begin
          pc_d = pc_plus2;
          if (!if_id_valid_q || !stall) begin
            if_id_valid_d = 1'b1;
            if_id_ir_d    = imem_rdata;
            if_id_pc_d    = pc_plus2;
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end else if (!stall) begin
          if_id_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (!stall && skid_full) begin
          if_id_valid_d = 1'b1;
          if_id_ir_d    = skid_data;
          if_id_pc_d    = skid_pc;
          skid_clear    = 1'b1;
          state_d       = FETCH;
        end
      end

      FLUSH: begin
        // A response arriving with a fresh redirect still closes the stale request.
        if (redirect) begin
          if (imem_resp) begin
            pc_d    = redirect_pc;
            state_d = FETCH;
          end else begin
            pending_pc_d = redirect_pc;
          end
        end else if (imem_resp) begin
          pc_d    = pending_pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Stage registers with synchronous reset; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= PC_RESET;
      pending_pc_q  <= PC_RESET;
      if_id_valid_q <= 1'b0;
      if_id_ir_q    <= 16'h0000;
      if_id_pc_q    <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pending_pc_q  <= pending_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_ir_q    <= if_id_ir_d;
      if_id_pc_q    <= if_id_pc_d;
    end
  end

  assign imem_read    = (state_q != HOLD);
  assign imem_address = pc_q;
  assign if_id_valid  = if_id_valid_q;
  assign if_id_ir     = if_id_ir_q;
  assign if_id_pc     = if_id_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for the fetch stage
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_id_valid;
  logic [15:0] if_id_ir;
  logic [15:0] if_id_pc;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_valid  (if_id_valid),
    .if_id_ir     (if_id_ir),
    .if_id_pc     (if_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, clock it, and settle 1 ns past the edge.
  task automatic step(input logic rsp, input logic [15:0] rd, input logic stl,
                      input logic rdr, input logic [15:0] rpc);
    imem_resp   = rsp;
    imem_rdata  = rd;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", if_id_valid); end
    n_checks++; if (if_id_ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h exp 0000", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h exp 0000", if_id_pc); end
    n_checks++; if (imem_read !== 1'b1) begin n_fail++; $display("FAIL reset_read: got %b exp 1", imem_read); end
    n_checks++; if (imem_address !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h exp 0000", imem_address); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_checks++; if (imem_address !== 16'h0000) begin n_fail++; $display("FAIL basic_addr0: got %h exp 0000", imem_address); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid0: got %b exp 0", if_id_valid); end
    step(1'b1, 16'h1261, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid1: got %b exp 1", if_id_valid); end
    n_checks++; if (if_id_ir !== 16'h1261) begin n_fail++; $display("FAIL basic_ir1: got %h exp 1261", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h0002) begin n_fail++; $display("FAIL basic_pc1: got %h exp 0002", if_id_pc); end
    n_checks++; if (imem_address !== 16'h0002) begin n_fail++; $display("FAIL basic_addr1: got %h exp 0002", imem_address); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed: got %b exp 0", if_id_valid); end
    n_checks++; if (if_id_ir !== 16'h1261) begin n_fail++; $display("FAIL basic_ir_kept: got %h exp 1261", if_id_ir); end
    step(1'b1, 16'h5020, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_ir !== 16'h5020) begin n_fail++; $display("FAIL basic_ir2: got %h exp 5020", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h0004) begin n_fail++; $display("FAIL basic_pc2: got %h exp 0004", if_id_pc); end
    n_checks++; if (imem_address !== 16'h0004) begin n_fail++; $display("FAIL basic_addr2: got %h exp 0004", imem_address); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    step(1'b1, 16'h1261, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_held: got %b exp 1", if_id_valid); end
    step(1'b1, 16'h5020, 1'b1, 1'b0, 16'h0);
    n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL stall_hold_read: got %b exp 0", imem_read); end
    n_checks++; if (if_id_ir !== 16'h1261) begin n_fail++; $display("FAIL stall_hold_ir: got %h exp 1261", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h0002) begin n_fail++; $display("FAIL stall_hold_pc: got %h exp 0002", if_id_pc); end
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL stall_hold2_read: got %b exp 0", imem_read); end
    n_checks++; if (if_id_ir !== 16'h1261) begin n_fail++; $display("FAIL stall_hold2_ir: got %h exp 1261", if_id_ir); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_ir !== 16'h5020) begin n_fail++; $display("FAIL stall_release_ir: got %h exp 5020", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h0004) begin n_fail++; $display("FAIL stall_release_pc: got %h exp 0004", if_id_pc); end
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release_valid: got %b exp 1", if_id_valid); end
    n_checks++; if (imem_read !== 1'b1) begin n_fail++; $display("FAIL stall_release_read: got %b exp 1", imem_read); end
    n_checks++; if (imem_address !== 16'h0004) begin n_fail++; $display("FAIL stall_release_addr: got %h exp 0004", imem_address); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    step(1'b1, 16'h1261, 1'b0, 1'b0, 16'h0);
    step(1'b1, 16'h5020, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h3000);
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", if_id_valid); end
    n_checks++; if (imem_address !== 16'h0004) begin n_fail++; $display("FAIL flush_addr_held: got %h exp 0004", imem_address); end
    n_checks++; if (imem_read !== 1'b1) begin n_fail++; $display("FAIL flush_read: got %b exp 1", imem_read); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_checks++; if (imem_address !== 16'h0004) begin n_fail++; $display("FAIL flush_addr_held2: got %h exp 0004", imem_address); end
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0);
    n_checks++; if (imem_address !== 16'h3000) begin n_fail++; $display("FAIL flush_target: got %h exp 3000", imem_address); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard_valid: got %b exp 0", if_id_valid); end
    n_checks++; if (if_id_ir !== 16'h5020) begin n_fail++; $display("FAIL flush_discard_ir: got %h exp 5020", if_id_ir); end
    step(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_ir !== 16'h1111) begin n_fail++; $display("FAIL flush_next_ir: got %h exp 1111", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h3002) begin n_fail++; $display("FAIL flush_next_pc: got %h exp 3002", if_id_pc); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    step(1'b1, 16'h1261, 1'b0, 1'b0, 16'h0);
    step(1'b1, 16'h5020, 1'b1, 1'b0, 16'h0);
    n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL rhold_in_hold: got %b exp 0", imem_read); end
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h4000);
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rhold_valid: got %b exp 0", if_id_valid); end
    n_checks++; if (imem_read !== 1'b1) begin n_fail++; $display("FAIL rhold_read: got %b exp 1", imem_read); end
    n_checks++; if (imem_address !== 16'h4000) begin n_fail++; $display("FAIL rhold_addr: got %h exp 4000", imem_address); end
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rhold_skid_cleared: got %b exp 0", if_id_valid); end
    step(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_ir !== 16'h2222) begin n_fail++; $display("FAIL rhold_next_ir: got %h exp 2222", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h4002) begin n_fail++; $display("FAIL rhold_next_pc: got %h exp 4002", if_id_pc); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    step(1'b1, 16'h7777, 1'b0, 1'b1, 16'hFFFE);
    n_checks++; if (imem_address !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr_pre: got %h exp fffe", imem_address); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_discard: got %b exp 0", if_id_valid); end
    step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b exp 1", if_id_valid); end
    n_checks++; if (if_id_pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h exp 0000", if_id_pc); end
    n_checks++; if (imem_address !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got %h exp 0000", imem_address); end
  endtask

  task automatic test_double_redirect();
    do_reset();
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h3000);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h5000);
    n_checks++; if (imem_address !== 16'h0000) begin n_fail++; $display("FAIL dbl_addr_held: got %h exp 0000", imem_address); end
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    n_checks++; if (imem_address !== 16'h5000) begin n_fail++; $display("FAIL dbl_target: got %h exp 5000", imem_address); end
    n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL dbl_valid: got %b exp 0", if_id_valid); end
    step(1'b1, 16'h3333, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_ir !== 16'h3333) begin n_fail++; $display("FAIL dbl_ir: got %h exp 3333", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h5002) begin n_fail++; $display("FAIL dbl_pc: got %h exp 5002", if_id_pc); end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    step(1'b1, 16'h1261, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h3000);
    do_reset();
    n_checks++; if (imem_address !== 16'h0000) begin n_fail++; $display("FAIL midrst_addr: got %h exp 0000", imem_address); end
    n_checks++; if (if_id_ir !== 16'h0000) begin n_fail++; $display("FAIL midrst_ir: got %h exp 0000", if_id_ir); end
    step(1'b1, 16'h4444, 1'b0, 1'b0, 16'h0);
    n_checks++; if (if_id_ir !== 16'h4444) begin n_fail++; $display("FAIL midrst_late_ir: got %h exp 4444", if_id_ir); end
    n_checks++; if (if_id_pc !== 16'h0002) begin n_fail++; $display("FAIL midrst_late_pc: got %h exp 0002", if_id_pc); end
    n_checks++; if (imem_address !== 16'h0002) begin n_fail++; $display("FAIL midrst_next_addr: got %h exp 0002", imem_address); end
  endtask

  initial begin
    reset       = 1'b1;
    imem_resp   = 1'b0;
    imem_rdata  = 16'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_redirect_flush();
    test_redirect_hold();
    test_pc_wrap();
    test_double_redirect();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 imem_read  output  1  instruction-memory read request.
REQ-004 imem_address  output  16  fetch address (lc3b_word).
REQ-005 imem_resp  input  1  one-cycle pulse: imem_rdata valid this cycle.
REQ-006 imem_rdata  input  16  fetched instruction word.
REQ-007 stall  input  1  decode stage cannot accept; IF/ID register must hold.
REQ-008 redirect  input  1  taken branch/jump: flush and refetch from redirect_pc.
REQ-009 redirect_pc  input  16  redirect target, sampled only when redirect=1.
REQ-010 if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-011 if_id_ir  output  16  instruction presented to the decode stage's control ROM.
REQ-012 if_id_pc  output  16  address of that instruction + 2.

Function
REQ-013 The FSM SHALL have three states: FETCH (imem_read=1), HOLD (imem_read=0, skid full), FLUSH (imem_read=1, response to be discarded).
REQ-014 imem_address SHALL equal the pc register and SHALL stay stable while imem_read=1 until imem_resp.
REQ-015 FETCH, imem_resp, no redirect, IF/ID free (!if_id_valid or !stall): load IF/ID with ir=imem_rdata, pc=pc+2, valid=1; pc<=pc+2; stay FETCH.
REQ-016 FETCH, imem_resp, no redirect, IF/ID occupied and stall: capture rdata and pc+2 in a one-entry skid; pc<=pc+2; go HOLD.
REQ-017 HOLD: when stall=0, move skid into IF/ID (valid=1) and go FETCH; otherwise hold everything.
REQ-018 FETCH, no imem_resp, !stall: valid<=0 when IF/ID consumed; no other change.
REQ-019 PC arithmetic SHALL be 16-bit modulo; 0xFFFE+2 = 0x0000.
REQ-020 redirect SHALL take priority over stall and imem_resp in every state; if_id_valid<=0 and skid cleared in the same edge.
REQ-021 redirect in FETCH with imem_resp, or in HOLD: discard data, pc<=redirect_pc, go FETCH.
REQ-022 redirect in FETCH without imem_resp: latch redirect_pc into pending_pc, go FLUSH.
REQ-023 FLUSH: keep request at old address; on imem_resp discard rdata, pc<=pending_pc, go FETCH; a further redirect overwrites pending_pc.
REQ-024 Latency: imem_resp in cycle N -> if_id_valid=1 with that instruction in cycle N+1 (no stall, no redirect).
REQ-025 if_id_ir and if_id_pc SHALL change only when IF/ID loads; flush clears valid only.

Reset
REQ-026 On reset: state=FETCH, pc=0x0000, pending_pc=0x0000, skid empty, if_id_valid=0, if_id_ir=0x0000, if_id_pc=0x0000.
REQ-027 First cycle after reset release: imem_read=1, imem_address=0x0000.
REQ-028 Reset mid-fetch SHALL abandon the request; a late imem_resp in the first post-reset cycle is accepted as the response to address 0x0000.

Structure
REQ-029 lc3b_word and an lc3b_if_state enum (FETCH, HOLD, FLUSH) SHALL live in package lc3b_types.
REQ-030 The skid entry SHALL be a sub-module if_skid_buffer (load, clear, data/pc in, full flag out); the rest is flat.

Verification
REQ-031 Reset, memory returns 0x1261 then 0x5020 with 1-cycle latency, stall=0 -> IF/ID shows (0x1261, pc 0x0002) then (0x5020, pc 0x0004); addresses 0x0000, 0x0002, 0x0004.
REQ-032 stall=1 while IF/ID holds 0x1261, resp delivers 0x5020 -> HOLD, imem_read=0, IF/ID unchanged; stall drops -> IF/ID=0x5020, read resumes at 0x0004.
REQ-033 redirect to 0x3000 while fetch of 0x0004 pending (no resp) -> FLUSH, address held 0x0004; resp data discarded; next request at 0x3000; if_id_valid=0 meanwhile.
REQ-034 redirect to 0x4000 in HOLD with stall=1 -> skid and IF/ID cleared, next request at 0x4000.
REQ-035 pc=0xFFFE, resp 0x0000 -> if_id_pc=0x0000, next address 0x0000.
REQ-036 Second redirect (0x5000) during FLUSH after first (0x3000) -> next request at 0x5000.
